// File: rtl/vga_multi_sprite_core.sv
`default_nettype none
// ============================================================================
// Module   : vga_multi_sprite_core
// Purpose  : Video-chain stage compositing NS prioritised sprites with key
//            colour transparency and a per-frame pixel-collision mask.
// Revision : 1.0 - initial release
// ============================================================================
module vga_multi_sprite_core #(
    parameter int CD        = 12,
    parameter int NS        = 4,
    parameter int SW        = 32,
    parameter int SH        = 32,
    parameter int KEY_COLOR = 0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [10:0]   x,
    input  logic [10:0]   y,
    input  logic          cs,
    input  logic          write,
    input  logic [13:0]   addr,
    input  logic [31:0]   wr_data,
    output logic [31:0]   rd_data,
    input  logic [CD-1:0] si_rgb,
    output logic [CD-1:0] so_rgb
);

    localparam int             c_P   = $clog2(SW * SH);
    localparam int             c_S   = $clog2(NS);
    localparam int             c_LW  = $clog2(SW);
    localparam int             c_LH  = $clog2(SH);
    localparam logic [CD-1:0]  c_KEY = CD'(KEY_COLOR);
    localparam logic [NS-1:0]  c_ONE = NS'(1);

    if (c_P + c_S > 13) begin : g_bad_params
        $error("vga_multi_sprite_core: clog2(NS)+clog2(SW*SH) exceeds 13");
    end

    // Slot bus decode
    logic           w_wr;
    logic           w_bm_wr;
    logic           w_sr_wr;
    logic           w_gl_wr;
    logic [3:0]     w_bm_spr;
    logic [c_P-1:0] w_bm_pix;
    logic [3:0]     w_sr_idx;
    logic [1:0]     w_sr_reg;
    logic           w_unused;

    assign w_wr     = cs & write;
    assign w_bm_wr  = w_wr & addr[13];
    assign w_sr_wr  = w_wr & (addr[13:12] == 2'b00);
    assign w_gl_wr  = w_wr & (addr[13:12] == 2'b01);
    assign w_bm_pix = addr[c_P-1:0];
    assign w_sr_idx = addr[5:2];
    assign w_sr_reg = addr[1:0];
    assign w_unused = ^{wr_data, addr};

    if (c_S > 0) begin : g_multi_idx
        assign w_bm_spr = 4'(addr[c_P+c_S-1:c_P]);
    end else begin : g_single_idx
        assign w_bm_spr = 4'd0;
    end

    // Per-sprite position / control registers
    logic [11:0] r_xpos [NS];
    logic [11:0] r_ypos [NS];
    logic [2:0]  r_ctrl [NS];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NS; i++) begin
                r_xpos[i] <= '0;
                r_ypos[i] <= '0;
                r_ctrl[i] <= '0;
            end
        end else if (w_sr_wr) begin
            for (int i = 0; i < NS; i++) begin
                if (w_sr_idx == 4'(i)) begin
                    case (w_sr_reg)
                        2'd0:    r_xpos[i] <= wr_data[11:0];
                        2'd1:    r_ypos[i] <= wr_data[11:0];
                        2'd2:    r_ctrl[i] <= wr_data[2:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    logic [NS-1:0]          w_hit;
    logic [NS-1:0][CD-1:0]  w_pix;

    for (genvar i = 0; i < NS; i++) begin : g_spr
        logic [12:0]     w_dx;
        logic [12:0]     w_dy;
        logic [c_LW-1:0] w_col;
        logic [c_LH-1:0] w_row;
        logic [CD-1:0]   r_mem [SW*SH];
        logic [CD-1:0]   r_q;

        // Unsigned pixel counter minus sign-extended position gives a
        // signed offset; the upper bits being zero means 0 <= d < size.
        assign w_dx     = {2'b00, x} - {r_xpos[i][11], r_xpos[i]};
        assign w_dy     = {2'b00, y} - {r_ypos[i][11], r_ypos[i]};
        assign w_hit[i] = r_ctrl[i][0] & (w_dx[12:c_LW] == '0) & (w_dy[12:c_LH] == '0);
        assign w_col    = r_ctrl[i][1] ? ~w_dx[c_LW-1:0] : w_dx[c_LW-1:0];
        assign w_row    = r_ctrl[i][2] ? ~w_dy[c_LH-1:0] : w_dy[c_LH-1:0];

        always_ff @(posedge clk) begin
            if (w_bm_wr && (w_bm_spr == 4'(i))) begin
                r_mem[w_bm_pix] <= wr_data[CD-1:0];
            end
            r_q <= r_mem[{w_row, w_col}];
        end

        assign w_pix[i] = r_q;
    end

    // Stage 1: hit flags travel alongside the upstream pixel
    logic [NS-1:0] r_hit;
    logic [CD-1:0] r_si;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_hit <= '0;
            r_si  <= '0;
        end else begin
            r_hit <= w_hit;
            r_si  <= si_rgb;
        end
    end

    // Stage 2: priority composite and collision detection
    logic [NS-1:0] w_opq;
    logic [NS-1:0] w_coll;
    logic [CD-1:0] w_top;

    always_comb begin
        w_opq  = '0;
        w_coll = '0;
        for (int i = 0; i < NS; i++) begin
            w_opq[i] = r_hit[i] && (w_pix[i] != c_KEY);
        end
        for (int i = 0; i < NS; i++) begin
            w_coll[i] = w_opq[i] && ((w_opq & ~(c_ONE << i)) != '0);
        end
    end

    always_comb begin
        w_top = r_si;
        for (int i = NS - 1; i >= 0; i--) begin
            if (w_opq[i]) w_top = w_pix[i];
        end
    end

    // Global state
    logic          r_bypass;
    logic [NS-1:0] r_status;
    logic [NS-1:0] r_acc;
    logic [31:0]   r_frame_cnt;
    logic          r_at_origin;
    logic [CD-1:0] r_so_rgb;
    logic          w_origin;
    logic          w_frame;
    logic          w_ctl_wr;

    assign w_origin = (x == 11'd0) && (y == 11'd0);
    assign w_frame  = w_origin & ~r_at_origin;
    assign w_ctl_wr = w_gl_wr && (addr[1:0] == 2'd2);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_bypass    <= 1'b0;
            r_status    <= '0;
            r_acc       <= '0;
            r_frame_cnt <= '0;
            r_at_origin <= 1'b0;
            r_so_rgb    <= '0;
        end else begin
            r_at_origin <= w_origin;
            r_acc       <= w_frame ? w_coll : (r_acc | w_coll);
            if (w_frame) begin
                r_status    <= r_acc;
                r_frame_cnt <= r_frame_cnt + 32'd1;
            end else if (w_ctl_wr && wr_data[1]) begin
                r_status <= '0;
            end
            if (w_ctl_wr) r_bypass <= wr_data[0];
            r_so_rgb <= r_bypass ? r_si : w_top;
        end
    end

    assign so_rgb = r_so_rgb;

    always_comb begin
        rd_data = '0;
        if (!addr[13]) begin
            if (!addr[12]) begin
                for (int i = 0; i < NS; i++) begin
                    if (w_sr_idx == 4'(i)) begin
                        case (w_sr_reg)
                            2'd0:    rd_data = {20'd0, r_xpos[i]};
                            2'd1:    rd_data = {20'd0, r_ypos[i]};
                            2'd2:    rd_data = {29'd0, r_ctrl[i]};
                            default: rd_data = '0;
                        endcase
                    end
                end
            end else begin
                case (addr[1:0])
                    2'd0:    rd_data = 32'(r_status);
                    2'd1:    rd_data = r_frame_cnt;
                    2'd2:    rd_data = {31'd0, r_bypass};
                    default: rd_data = '0;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
